// File: rtl/nucore_pkg.sv
// Shared Nucore datapath definitions: widths, ALU opcodes and the
// opcode-validity predicate.
package nucore_pkg;

   localparam int N_WIDTH = 32;
   localparam int REG_AW  = 4;
   localparam int CTRL_W  = 3;

   typedef logic [CTRL_W-1:0] alu_op_t;

   localparam alu_op_t ALU_ADD = 3'b011;
   localparam alu_op_t ALU_SUB = 3'b100;
   localparam alu_op_t ALU_OR  = 3'b101;
   localparam alu_op_t ALU_AND = 3'b110;
   localparam alu_op_t ALU_SHL = 3'b111;

   function automatic logic is_valid_op(input alu_op_t op);
      return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_OR) ||
             (op == ALU_AND) || (op == ALU_SHL);
   endfunction

endpackage

// File: rtl/nucore_regfile.sv
// Register file: two combinational read ports, one synchronous write
// port, R0 hardwired to zero, synchronous active-low clear.
module nucore_regfile
   import nucore_pkg::*;
#(
   parameter int n    = N_WIDTH,
   parameter int NREG = 16,
   localparam int RAW = $clog2(NREG)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           we,
   input  logic [RAW-1:0] waddr,
   input  logic [n-1:0]   wdata,
   input  logic [RAW-1:0] raddr_a,
   output logic [n-1:0]   rdata_a,
   input  logic [RAW-1:0] raddr_b,
   output logic [n-1:0]   rdata_b
);

   logic [n-1:0] mem [NREG];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) mem[i] <= '0;
      end else if (we && (waddr != '0)) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata_a = (raddr_a == '0) ? '0 : mem[raddr_a];
   assign rdata_b = (raddr_b == '0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-entry stage: owns the register file, resolves operands with
// forwarding and holds them in the ID/EX register driving the ALU.
module alu_operand_stage
   import nucore_pkg::*;
#(
   parameter int n    = N_WIDTH,
   parameter int NREG = 16,
   localparam int RAW = $clog2(NREG)
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           InValid,
   output logic           InReady,
   input  logic [2:0]     InCtrl,
   input  logic [RAW-1:0] InRA,
   input  logic [RAW-1:0] InRB,
   input  logic [RAW-1:0] InRD,
   input  logic [n-1:0]   InImm,
   input  logic           InUseImm,
   output logic           OutValid,
   input  logic           OutReady,
   output logic [n-1:0]   OPA,
   output logic [n-1:0]   OPB,
   output logic [2:0]     ALUCtrl,
   output logic [RAW-1:0] OutRD,
   input  logic [n-1:0]   ALUResult,
   input  logic           WBEn,
   input  logic [RAW-1:0] WBAddr,
   input  logic [n-1:0]   WBData
);

   logic           vld_p1;
   logic [n-1:0]   opa_p1, opb_p1;
   alu_op_t        ctrl_p1;
   logic [RAW-1:0] rd_p1;

   logic           pend_valid;
   logic [RAW-1:0] pend_rd;
   logic [n-1:0]   pend_data;

   logic           handoff, accept;
   logic [n-1:0]   rf_a, rf_b;
   logic [n-1:0]   opa_p0, opb_p0, opb_reg;

   nucore_regfile #(.n(n), .NREG(NREG)) u_regfile (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (WBEn),
      .waddr   (WBAddr),
      .wdata   (WBData),
      .raddr_a (InRA),
      .rdata_a (rf_a),
      .raddr_b (InRB),
      .rdata_b (rf_b)
   );

   // Priority: in-flight ALU result, then pending entry, then write-back
   // strobe, then stored value; R0 never forwards.
   function automatic logic [n-1:0] resolve(
      input logic [RAW-1:0] s,
      input logic [n-1:0]   rf_val,
      input logic           ho,
      input logic [RAW-1:0] ho_rd,
      input logic [n-1:0]   alu_res,
      input logic           pv,
      input logic [RAW-1:0] prd,
      input logic [n-1:0]   pdata,
      input logic           wben,
      input logic [RAW-1:0] wbaddr,
      input logic [n-1:0]   wbdata
   );
      if (s == '0)                  return '0;
      if (ho && (ho_rd == s))       return alu_res;
      if (pv && (prd == s))         return pdata;
      if (wben && (wbaddr == s))    return wbdata;
      return rf_val;
   endfunction

   assign handoff = vld_p1 && OutReady;
   assign InReady = !vld_p1 || OutReady;
   assign accept  = InValid && InReady;

   // Stage p0: operand resolution for the instruction being accepted
   always_comb begin
      opa_p0  = resolve(InRA, rf_a, handoff, rd_p1, ALUResult,
                        pend_valid, pend_rd, pend_data, WBEn, WBAddr, WBData);
      opb_reg = resolve(InRB, rf_b, handoff, rd_p1, ALUResult,
                        pend_valid, pend_rd, pend_data, WBEn, WBAddr, WBData);
      opb_p0  = InUseImm ? InImm : opb_reg;
   end

   // Stage p1: ID/EX register feeding the ALU
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_p1  <= 1'b0;
         opa_p1  <= '0;
         opb_p1  <= '0;
         ctrl_p1 <= '0;
         rd_p1   <= '0;
      end else if (accept) begin
         vld_p1  <= 1'b1;
         opa_p1  <= opa_p0;
         opb_p1  <= opb_p0;
         ctrl_p1 <= InCtrl;
         rd_p1   <= is_valid_op(InCtrl) ? InRD : '0;
      end else if (handoff) begin
         vld_p1  <= 1'b0;
      end
   end

   // A fresh load takes precedence over a matching write-back clear.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pend_valid <= 1'b0;
         pend_rd    <= '0;
         pend_data  <= '0;
      end else if (handoff && (rd_p1 != '0)) begin
         pend_valid <= 1'b1;
         pend_rd    <= rd_p1;
         pend_data  <= ALUResult;
      end else if (pend_valid && WBEn && (WBAddr == pend_rd)) begin
         pend_valid <= 1'b0;
      end
   end

   assign OutValid = vld_p1;
   assign OPA      = opa_p1;
   assign OPB      = opb_p1;
   assign ALUCtrl  = ctrl_p1;
   assign OutRD    = rd_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, forwarding paths, stall,
// write-through bypass, R0 handling and reset during a stall.
module tb_alu_operand_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        InValid, InReady, InUseImm, OutValid, OutReady, WBEn;
   logic [2:0]  InCtrl, ALUCtrl;
   logic [3:0]  InRA, InRB, InRD, OutRD, WBAddr;
   logic [31:0] InImm, OPA, OPB, ALUResult, WBData;

   int n_checks = 0;
   int n_fail   = 0;

   alu_operand_stage #(.n(32), .NREG(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .InValid(InValid), .InReady(InReady), .InCtrl(InCtrl),
      .InRA(InRA), .InRB(InRB), .InRD(InRD), .InImm(InImm), .InUseImm(InUseImm),
      .OutValid(OutValid), .OutReady(OutReady),
      .OPA(OPA), .OPB(OPB), .ALUCtrl(ALUCtrl), .OutRD(OutRD),
      .ALUResult(ALUResult), .WBEn(WBEn), .WBAddr(WBAddr), .WBData(WBData)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] ctrl, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rd, input logic use_imm, input logic [31:0] imm);
      InValid = 1'b1; InCtrl = ctrl; InRA = ra; InRB = rb; InRD = rd;
      InUseImm = use_imm; InImm = imm;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; InValid = 1'b0; OutReady = 1'b1; WBEn = 1'b0;
      InCtrl = '0; InRA = '0; InRB = '0; InRD = '0; InImm = '0; InUseImm = 1'b0;
      ALUResult = '0; WBAddr = '0; WBData = '0;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL reset_outvalid: got %b expected 0", OutValid); end
      n_checks++; if (OPA !== 32'h0) begin n_fail++; $display("FAIL reset_opa: got %h expected 0", OPA); end
      n_checks++; if (OPB !== 32'h0) begin n_fail++; $display("FAIL reset_opb: got %h expected 0", OPB); end
      n_checks++; if (ALUCtrl !== 3'b000) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 000", ALUCtrl); end
      n_checks++; if (OutRD !== 4'd0) begin n_fail++; $display("FAIL reset_outrd: got %0d expected 0", OutRD); end
      n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL reset_inready: got %b expected 1", InReady); end
   endtask

   task automatic test_basic_read();
      WBEn = 1'b1; WBAddr = 4'd3; WBData = 32'h10;
      tick();
      WBEn = 1'b0;
      issue(3'b011, 4'd3, 4'd0, 4'd1, 1'b0, 32'h0);
      ALUResult = 32'h10;
      tick();
      InValid = 1'b0;
      n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL basic_outvalid: got %b expected 1", OutValid); end
      n_checks++; if (OPA !== 32'h10) begin n_fail++; $display("FAIL basic_opa: got %h expected 10", OPA); end
      n_checks++; if (OPB !== 32'h0) begin n_fail++; $display("FAIL basic_opb: got %h expected 0", OPB); end
      n_checks++; if (ALUCtrl !== 3'b011) begin n_fail++; $display("FAIL basic_ctrl: got %b expected 011", ALUCtrl); end
      n_checks++; if (OutRD !== 4'd1) begin n_fail++; $display("FAIL basic_outrd: got %0d expected 1", OutRD); end
      tick();
      n_checks++; if (OutValid !== 1'b0) begin n_fail++; $display("FAIL basic_drain: got %b expected 0", OutValid); end
   endtask

   task automatic test_back_to_back();
      issue(3'b011, 4'd3, 4'd0, 4'd2, 1'b1, 32'h5);
      tick();
      n_checks++; if (OPA !== 32'h10) begin n_fail++; $display("FAIL b2b_first_opa: got %h expected 10", OPA); end
      n_checks++; if (OPB !== 32'h5) begin n_fail++; $display("FAIL b2b_first_imm: got %h expected 5", OPB); end
      issue(3'b100, 4'd2, 4'd3, 4'd4, 1'b0, 32'h0);
      ALUResult = 32'h15;
      #1;
      n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL b2b_inready: got %b expected 1", InReady); end
      tick();
      InValid = 1'b0;
      n_checks++; if (OutValid !== 1'b1) begin n_fail++; $display("FAIL b2b_outvalid: got %b expected 1", OutValid); end
      n_checks++; if (OPA !== 32'h15) begin n_fail++; $display("FAIL b2b_fwd_opa: got %h expected 15", OPA); end
      n_checks++; if (OPB !== 32'h10) begin n_fail++; $display("FAIL b2b_opb: got %h expected 10", OPB); end
      n_checks++; if (ALUCtrl !== 3'b100 || OutRD !== 4'd4) begin n_fail++; $display("FAIL b2b_ctrl_rd: got %b/%0d expected 100/4", ALUCtrl, OutRD); end
      ALUResult = 32'h5;
      tick();
      // R4 now lives only in the pending entry
      issue(3'b101, 4'd4, 4'd4, 4'd5, 1'b0, 32'h0);
      tick();
      InValid = 1'b0;
      n_checks++; if (OPA !== 32'h5 || OPB !== 32'h5) begin n_fail++; $display("FAIL pend_fwd: got %h/%h expected 5/5", OPA, OPB); end
      tick();
   endtask

   task automatic test_stall();
      issue(3'b110, 4'd3, 4'd0, 4'd6, 1'b1, 32'hFF);
      ALUResult = 32'h77;
      tick();
      OutReady = 1'b0;
      issue(3'b011, 4'd6, 4'd0, 4'd8, 1'b0, 32'h0);
      #1;
      n_checks++; if (InReady !== 1'b0) begin n_fail++; $display("FAIL stall_inready: got %b expected 0", InReady); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if (OutValid !== 1'b1 || OPA !== 32'h10 || OPB !== 32'hFF || ALUCtrl !== 3'b110 || OutRD !== 4'd6 || InReady !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_hold[%0d]: got v=%b a=%h b=%h c=%b rd=%0d rdy=%b expected v=1 a=10 b=ff c=110 rd=6 rdy=0",
                     i, OutValid, OPA, OPB, ALUCtrl, OutRD, InReady);
         end
      end
      OutReady = 1'b1;
      #1;
      n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b expected 1", InReady); end
      tick();
      InValid = 1'b0;
      n_checks++; if (OutValid !== 1'b1 || ALUCtrl !== 3'b011 || OutRD !== 4'd8) begin n_fail++; $display("FAIL stall_release_accept: got v=%b c=%b rd=%0d expected 1/011/8", OutValid, ALUCtrl, OutRD); end
      n_checks++; if (OPA !== 32'h77) begin n_fail++; $display("FAIL stall_release_fwd: got %h expected 77", OPA); end
      tick();
   endtask

   task automatic test_wb_bypass();
      WBEn = 1'b1; WBAddr = 4'd7; WBData = 32'hAB;
      issue(3'b101, 4'd7, 4'd0, 4'd9, 1'b0, 32'h0);
      ALUResult = 32'hAB;
      tick();
      WBEn = 1'b0; InValid = 1'b0;
      n_checks++; if (OPA !== 32'hAB || OPB !== 32'h0) begin n_fail++; $display("FAIL wb_bypass: got %h/%h expected ab/0", OPA, OPB); end
      tick();
      issue(3'b101, 4'd0, 4'd7, 4'd10, 1'b0, 32'h0);
      ALUResult = 32'h0;
      tick();
      InValid = 1'b0;
      n_checks++; if (OPA !== 32'h0 || OPB !== 32'hAB) begin n_fail++; $display("FAIL wb_stored: got %h/%h expected 0/ab", OPA, OPB); end
      ALUResult = 32'hAB;
      tick();
   endtask

   task automatic test_pend_clear();
      // Pending R10 = 0xAB; a write-back of 0x33 to R10 retires it
      WBEn = 1'b1; WBAddr = 4'd10; WBData = 32'h33;
      issue(3'b011, 4'd10, 4'd0, 4'd11, 1'b0, 32'h0);
      tick();
      WBEn = 1'b0;
      n_checks++; if (OPA !== 32'hAB) begin n_fail++; $display("FAIL pend_over_wb: got %h expected ab", OPA); end
      issue(3'b011, 4'd10, 4'd0, 4'd12, 1'b0, 32'h0);
      ALUResult = 32'h99;
      tick();
      InValid = 1'b0;
      n_checks++; if (OPA !== 32'h33) begin n_fail++; $display("FAIL pend_cleared: got %h expected 33", OPA); end
      ALUResult = 32'h0;
      tick();
   endtask

   task automatic test_r0_and_badop();
      WBEn = 1'b1; WBAddr = 4'd0; WBData = 32'hFF;
      issue(3'b011, 4'd0, 4'd0, 4'd13, 1'b0, 32'h0);
      tick();
      WBEn = 1'b0;
      n_checks++; if (OPA !== 32'h0 || OPB !== 32'h0) begin n_fail++; $display("FAIL r0_read: got %h/%h expected 0/0", OPA, OPB); end
      issue(3'b010, 4'd3, 4'd7, 4'd13, 1'b0, 32'h0);
      tick();
      InValid = 1'b0;
      n_checks++; if (ALUCtrl !== 3'b010 || OutRD !== 4'd0) begin n_fail++; $display("FAIL badop_pass: got %b/%0d expected 010/0", ALUCtrl, OutRD); end
      n_checks++; if (OPA !== 32'h10 || OPB !== 32'hAB) begin n_fail++; $display("FAIL badop_operands: got %h/%h expected 10/ab", OPA, OPB); end
      tick();
   endtask

   task automatic test_reset_midstall();
      issue(3'b011, 4'd3, 4'd0, 4'd14, 1'b0, 32'h0);
      ALUResult = 32'h55;
      tick();
      InValid = 1'b0;
      tick();
      issue(3'b100, 4'd14, 4'd3, 4'd15, 1'b0, 32'h0);
      tick();
      InValid = 1'b0; OutReady = 1'b0;
      n_checks++; if (OPA !== 32'h55) begin n_fail++; $display("FAIL prereset_pend: got %h expected 55", OPA); end
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      OutReady = 1'b1;
      #1;
      n_checks++; if (OutValid !== 1'b0 || OPA !== 32'h0 || OPB !== 32'h0 || ALUCtrl !== 3'b000 || OutRD !== 4'd0) begin
         n_fail++;
         $display("FAIL midstall_reset: got v=%b a=%h b=%h c=%b rd=%0d expected all 0", OutValid, OPA, OPB, ALUCtrl, OutRD);
      end
      n_checks++; if (InReady !== 1'b1) begin n_fail++; $display("FAIL midstall_inready: got %b expected 1", InReady); end
      issue(3'b101, 4'd14, 4'd3, 4'd1, 1'b0, 32'h0);
      tick();
      n_checks++; if (OPA !== 32'h0 || OPB !== 32'h0) begin n_fail++; $display("FAIL midstall_cleared: got %h/%h expected 0/0", OPA, OPB); end
      issue(3'b101, 4'd7, 4'd0, 4'd2, 1'b0, 32'h0);
      ALUResult = 32'h0;
      tick();
      InValid = 1'b0;
      n_checks++; if (OPA !== 32'h0) begin n_fail++; $display("FAIL midstall_r7: got %h expected 0", OPA); end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic_read();
      test_back_to_back();
      test_stall();
      test_wb_bypass();
      test_pend_clear();
      test_r0_and_badop();
      test_reset_midstall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
